// File: rtl/test_mem_pkg.sv
// Shared definitions for the wait-state test memory model: read FSM state
// encoding and the power-on / reset contents of the memory array.
package test_mem_pkg;

    // Read FSM state encoding (kept as plain localparams for older tools)
    typedef logic [1:0] rd_state_t;
    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_WAIT  = 2'd1;
    localparam rd_state_t ST_DRIVE = 2'd2;

    // Widest data bus the init pattern can serve; the memory keeps the low bits
    localparam int INIT_W = 64;

    // Selects the reset image: 0 = all zero, 1 = word index replicated
    localparam int INIT_MODE = 0;

    // Reset contents of word i; test programs change INIT_MODE or this body
    function automatic logic [INIT_W-1:0] init_word(input int unsigned i);
        case (INIT_MODE)
            1:       init_word = {4{i[15:0]}};
            default: init_word = '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Read-latency down counter: loaded when a read starts or its address moves,
// then decremented once per wait cycle until the data phase begins.
module mem_wait_ctr #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count;

    // Load has priority over decrement; the count never underflows past zero
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/test_memory_ws.sv
// Behavioural asynchronous-SRAM-style test memory with programmable read
// wait states, byte lanes, out-of-range detection and a committed-write count.
module test_memory_ws
    import test_mem_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    inout  wire  [DATA_W-1:0]   I_O,
    input  logic [ADDR_W-1:0]   A,
    input  logic                CE_N,
    input  logic                OE_N,
    input  logic                WE_N,
    input  logic [DATA_W/8-1:0] BE_N,
    output logic                Ready,
    output logic                Range_err,
    output logic [15:0]         Wr_count
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    rd_state_t         state;
    rd_state_t         state_next;
    logic [ADDR_W-1:0] a_prev;
    logic              acc_prev;

    logic              rd_cond;
    logic              wr_cond;
    logic              access;
    logic              in_range;
    logic              a_changed;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic              ctr_load;
    logic              ctr_dec;
    logic              ctr_zero;
    logic              ctr_last;

    assign rd_cond   = !CE_N && !OE_N && WE_N;
    assign wr_cond   = !CE_N && !WE_N;
    assign access    = rd_cond || wr_cond;
    assign a_changed = (A != a_prev);
    assign idx       = A[IDX_W-1:0];

    // Only the low IDX_W address bits are decoded; anything above must be zero
    generate
        if (IDX_W < ADDR_W) begin : g_range
            assign in_range = (A[ADDR_W-1:IDX_W] == '0);
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign rd_word = in_range ? mem[idx] : '0;

    mem_wait_ctr #(
        .W(4)
    ) u_wait_ctr (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (ctr_load),
        .load_val (4'(WAIT_STATES)),
        .dec      (ctr_dec),
        .zero     (ctr_zero),
        .last     (ctr_last)
    );

    // Read FSM next state; any new address restarts the latency window
    always_comb begin
        state_next = state;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        if (!rd_cond) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    ctr_load   = 1'b1;
                    state_next = (WAIT_STATES == 0) ? ST_DRIVE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (a_changed) begin
                        ctr_load   = 1'b1;
                        state_next = (WAIT_STATES == 0) ? ST_DRIVE : ST_WAIT;
                    end else begin
                        ctr_dec = 1'b1;
                        if (ctr_last || ctr_zero) begin
                            state_next = ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (a_changed) begin
                        ctr_load   = 1'b1;
                        state_next = (WAIT_STATES == 0) ? ST_DRIVE : ST_WAIT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state, last-seen address and out-of-range pulse generation
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            a_prev    <= '0;
            acc_prev  <= 1'b0;
            Range_err <= 1'b0;
        end else begin
            state     <= state_next;
            a_prev    <= A;
            acc_prev  <= access;
            Range_err <= access && !in_range && (!acc_prev || a_changed);
        end
    end

    // Memory array and write counter; reset reloads the initial image
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(init_word(i));
            end
            Wr_count <= '0;
        end else if (wr_cond && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (!BE_N[k]) begin
                    mem[idx][8*k +: 8] <= I_O[8*k +: 8];
                end
            end
            if (BE_N != {NB{1'b1}}) begin
                Wr_count <= Wr_count + 16'd1;
            end
        end
    end

    // Data is valid only in DRIVE with the read still asserted at the same address
    assign Ready = (state == ST_DRIVE) && rd_cond && !a_changed;

    generate
        for (genvar k = 0; k < NB; k++) begin : g_lane
            assign I_O[8*k +: 8] = (Ready && !BE_N[k]) ? rd_word[8*k +: 8] : 8'hzz;
        end
    endgenerate

endmodule

// File: tb/tb_test_memory_ws.sv
// Directed self-checking bench for test_memory_ws. Two instances share all
// control inputs: one with two wait states, one with three. Bus lanes carry
// pull-ups, so an undriven lane reads back as 8'hFF.
module tb_test_memory_ws;

    logic        Clk;
    logic        Reset_n;
    logic [19:0] A;
    logic        CE_N;
    logic        OE_N;
    logic        WE_N;
    logic [1:0]  BE_N;
    logic        tb_drv;
    logic [15:0] tb_data;

    wire  [15:0] io2;
    wire  [15:0] io3;
    logic        ready2;
    logic        ready3;
    logic        range_err2;
    logic        range_err3;
    logic [15:0] wr_count2;
    logic [15:0] wr_count3;

    int compared   = 0;
    int mismatched = 0;

    assign io2 = tb_drv ? tb_data : 16'hzzzz;
    assign io3 = tb_drv ? tb_data : 16'hzzzz;

    generate
        for (genvar k = 0; k < 16; k++) begin : g_pu
            pullup (io2[k]);
            pullup (io3[k]);
        end
    endgenerate

    test_memory_ws #(
        .ADDR_W(20), .DATA_W(16), .DEPTH(256), .WAIT_STATES(2)
    ) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .I_O(io2), .A(A), .CE_N(CE_N),
        .OE_N(OE_N), .WE_N(WE_N), .BE_N(BE_N), .Ready(ready2),
        .Range_err(range_err2), .Wr_count(wr_count2)
    );

    test_memory_ws #(
        .ADDR_W(20), .DATA_W(16), .DEPTH(256), .WAIT_STATES(3)
    ) u_dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .I_O(io3), .A(A), .CE_N(CE_N),
        .OE_N(OE_N), .WE_N(WE_N), .BE_N(BE_N), .Ready(ready3),
        .Range_err(range_err3), .Wr_count(wr_count3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drive the control/address inputs and let combinational outputs settle
    task automatic applyStimulus(input logic ce, input logic oe, input logic we,
                                 input logic [1:0] be, input logic [19:0] addr);
        CE_N = ce;
        OE_N = oe;
        WE_N = we;
        BE_N = be;
        A    = addr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        tb_drv  = 1'b0;
        tb_data = 16'h0000;
        CE_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; BE_N = 2'b11; A = '0;
        #12;
        checkOutput("rst_ready",  {15'd0, ready2},     16'h0000);
        checkOutput("rst_rerr",   {15'd0, range_err2}, 16'h0000);
        checkOutput("rst_wrcnt",  wr_count2,           16'h0000);
        checkOutput("rst_bus_z",  io2,                 16'hFFFF);
        Reset_n = 1'b1;
        step();

        // Read of word 5: two wait states on u_dut, three on u_dut3
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd5);
        checkOutput("rd5_pre",    {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("rd5_e0",     {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("rd5_e1",     {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("rd5_e2",     {15'd0, ready2}, 16'h0001);
        checkOutput("rd5_data",   io2,             16'h0000);
        checkOutput("rd5_ws3_e2", {15'd0, ready3}, 16'h0000);
        step();
        checkOutput("rd5_ws3_e3", {15'd0, ready3}, 16'h0001);

        // Writes: full word, partial lane, and a write with no lanes enabled
        tb_drv  = 1'b1;
        tb_data = 16'h5A5A;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'd0);
        checkOutput("wr_ready_low", {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("wr_cnt1",    wr_count2, 16'h0001);
        tb_data = 16'h1111;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'd7);
        step();
        tb_data = 16'hA5C3;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 20'd7);
        step();
        checkOutput("wr_cnt3",    wr_count2, 16'h0003);
        tb_data = 16'hC0DE;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'd4);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 20'd8);
        step();
        checkOutput("wr_nolane",  wr_count2, 16'h0004);
        checkOutput("wr_cnt_ws3", wr_count3, 16'h0004);

        // Read back the partially written word, then mask lane 0
        tb_drv = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd7);
        step();
        step();
        step();
        checkOutput("rd7_ready",  {15'd0, ready2}, 16'h0001);
        checkOutput("rd7_data",   io2,             16'h11C3);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 20'd7);
        checkOutput("rd7_lane0z", io2,             16'h11FF);

        // Write during a read: the bus is released and the new data appears later
        tb_drv  = 1'b1;
        tb_data = 16'h2468;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 20'd7);
        checkOutput("raw_ready",  {15'd0, ready2}, 16'h0000);
        checkOutput("raw_bus",    io2,             16'h2468);
        step();
        checkOutput("raw_cnt",    wr_count2,       16'h0005);
        tb_drv = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd7);
        checkOutput("raw_z",      io2,             16'hFFFF);
        step();
        step();
        step();
        checkOutput("raw_ready2", {15'd0, ready2}, 16'h0001);
        checkOutput("raw_data",   io2,             16'h2468);

        // Out-of-range accesses: writes dropped, reads return zero
        tb_drv  = 1'b1;
        tb_data = 16'hBEEF;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'h00100);
        step();
        checkOutput("oor_wr_pulse", {15'd0, range_err2}, 16'h0001);
        checkOutput("oor_wr_cnt",   wr_count2,           16'h0005);
        step();
        checkOutput("oor_wr_hold",  {15'd0, range_err2}, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'h00200);
        step();
        checkOutput("oor_new_addr", {15'd0, range_err2}, 16'h0001);
        tb_drv = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'h00100);
        step();
        checkOutput("oor_rd_pulse", {15'd0, range_err2}, 16'h0001);
        step();
        checkOutput("oor_rd_hold",  {15'd0, range_err2}, 16'h0000);
        step();
        checkOutput("oor_rd_ready", {15'd0, ready2},     16'h0001);
        checkOutput("oor_rd_data",  io2,                 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd0);
        step();
        step();
        step();
        checkOutput("oor_mem0",     io2,                 16'h5A5A);
        checkOutput("inr_rerr",     {15'd0, range_err2}, 16'h0000);

        // Address change mid-wait on the three-wait-state instance
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 20'd3);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd3);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd4);
        checkOutput("chg_e1",     {15'd0, ready3}, 16'h0000);
        step();
        step();
        checkOutput("chg_e3",     {15'd0, ready3}, 16'h0000);
        step();
        checkOutput("chg_e4",     {15'd0, ready3}, 16'h0000);
        step();
        checkOutput("chg_e5",     {15'd0, ready3}, 16'h0001);
        checkOutput("chg_data",   io3,             16'hC0DE);

        // Address change while driving drops Ready in the same cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 20'd7);
        checkOutput("drv_chg_rdy", {15'd0, ready2}, 16'h0000);
        checkOutput("drv_chg_z",   io2,             16'hFFFF);
        step();
        step();
        checkOutput("drv_chg_e1",  {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("drv_chg_e2",  {15'd0, ready2}, 16'h0001);
        checkOutput("drv_chg_dat", io2,             16'h2468);

        // Reset while driving: bus released at once, memory reloaded
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_z",   io2,             16'hFFFF);
        checkOutput("mid_rst_rdy", {15'd0, ready2}, 16'h0000);
        checkOutput("mid_rst_cnt", wr_count2,       16'h0000);
        step();
        #1;
        Reset_n = 1'b1;
        step();
        step();
        checkOutput("post_rst_e1", {15'd0, ready2}, 16'h0000);
        step();
        checkOutput("post_rst_rdy", {15'd0, ready2}, 16'h0001);
        checkOutput("post_rst_mem", io2,             16'h0000);

        // Write counter wrap
        tb_drv  = 1'b1;
        tb_data = 16'h0001;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 20'd1);
        repeat (65535) step();
        checkOutput("wrap_max",  wr_count2, 16'hFFFF);
        step();
        checkOutput("wrap_zero", wr_count2, 16'h0000);
        tb_drv = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 20'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
